axis_offset_gen: RTL and testbench
==================================

Name: axis_offset_gen

Overview:
Parametrised, registered successor to the per-axis pitch offset table. It maps a received stick value (pitch or roll) to per-motor offsets using a symmetric deadband and step law rather than a fixed table. Outputs are slew-limited so that offsets ramp rather than jump. A link-loss failsafe ramps the offsets back to zero. It sits between the receiver decode and the motor mixer, with one instance per axis.

Parameters:
- IN_W, 8: width of rec_val (unsigned).
- OUT_W, 8: width of each motor offset.
- CENTER, 20: rec_val neutral point.
- DEADBAND, 2: |rec_val-CENTER| <= DEADBAND gives zero offset.
- STEP, 3: input counts per offset level (>=1).
- MAX_OFFSET, 6: saturation level (must fit OUT_W).
- SLEW, 1: maximum change of the internal offset per update tick.
- TICK_DIV, 4: clocks per update tick (>=1).
- TIMEOUT_TICKS, 8: ticks without rec_valid before failsafe.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset.
- rec_val, input, IN_W: received stick value.
- rec_valid, input, 1: one-cycle strobe; rec_val is sampled when rec_valid=1.
- motor_1_offset, output, OUT_W: front-pair offset A.
- motor_2_offset, output, OUT_W: front-pair offset B (always equal to motor_1).
- motor_3_offset, output, OUT_W: rear-pair offset A.
- motor_4_offset, output, OUT_W: rear-pair offset B (always equal to motor_3).
- settled, output, 1: current offset equals target offset.
- link_lost, output, 1: failsafe active.

Interface: one clock, clk; reset rst is asynchronous and active-high.

Behaviour:
- Reset (async, immediate, including mid-ramp):
  - all offsets 0; settled=1; link_lost=0; state IDLE.
  - tick counter 0; timeout counter 0; target 0; current 0.
- Target law:
  - m = |rec_val - CENTER|, computed at IN_W+1 bits with no wrap.
  - If m <= DEADBAND, level=0.
  - Otherwise level = min(MAX_OFFSET, (m-DEADBAND-1)/STEP + 1), using integer division. Values far from CENTER saturate at MAX_OFFSET; they never fall back to 0.
  - Signed target: +level when rec_val > CENTER (drives motors 1/2); -level when rec_val < CENTER (drives motors 3/4).
- Latency: the target register updates on the clock after a rec_valid strobe.
- Tick: a free-running counter over 0..TICK_DIV-1; tick=1 when it wraps.
- Slew, on each tick:
  - current moves toward target by min(SLEW, |target-current|).
  - A sign reversal passes through 0; no tick ever jumps directly across zero.
  - Offsets never change between ticks.
- Outputs, registered from current:
  - current > 0: motors 1/2 = current; motors 3/4 = 0.
  - current < 0: motors 3/4 = |current|; motors 1/2 = 0.
  - current = 0: all offsets 0.
  - Outputs are valid the clock after current changes.
- settled = (current == target), registered.
- State machine:
  - IDLE: no valid value seen since reset; target held at 0. The first rec_valid moves to TRACK.
  - TRACK: each rec_valid reloads target and clears the timeout counter; each tick increments the timeout counter. When the counter reaches TIMEOUT_TICKS, move to FAILSAFE.
  - FAILSAFE: link_lost=1; target forced to 0; current ramps to 0 at SLEW per tick. A rec_valid returns to TRACK on the next clock with the new target, clears link_lost and restarts the timeout counter.
- Simultaneous events:
  - rec_valid and timeout expiry on the same cycle: rec_valid wins; stay in TRACK.
  - rec_valid and tick on the same cycle: the slew step uses the old target; the new target applies from the next tick.

Optional Feature:
- Macro: AXIS_OFFSET_GEN_TRIM_EN.
- When defined:
  - Adds input trim_val (signed, 5 bits) and trim_load (1 bit).
  - On trim_load, a trim register is loaded; the trim register resets to 0.
  - The effective center is CENTER+trim, clamped to 0..2^IN_W-1.
- When not defined: no trim ports; the center is the fixed CENTER.

Test Plan:
1. Reset, then rec_val=20 strobed -> all offsets 0, settled=1, state TRACK, link_lost=0.
2. rec_val=0 strobed (m=20 -> level 6, rear pair) -> motor_3/4 step 1,2,...,6, one step every 4 clocks; motor_1/2 stay 0; settled=1 after the 6th tick.
3. From steady motor_3/4=6, rec_val=40 strobed -> motor_3/4 fall 6..0 over 6 ticks, then motor_1/2 rise 1..6 over 6 ticks; no cycle has both pairs nonzero; 12 ticks in total.
4. Boundaries:
   - rec_val=22 -> 0.
   - rec_val=23 -> +1.
   - rec_val=26 -> +2.
   - rec_val=18 -> 0.
   - rec_val=17 -> -1 (motor_3/4=1).
   - rec_val=255 -> +6 (saturates).
5. Steady offsets of 4, then no rec_valid for 8 ticks -> link_lost=1 and offsets ramp 4..0 over 4 ticks. A following strobe of rec_val=30 -> link_lost=0 and ramp to +3.
6. Assert rst mid-ramp at offset 3 -> outputs 0 asynchronously, settled=1, IDLE. Further ticks with no strobe -> outputs stay 0 and link_lost stays 0.

Source files
------------

// File: rtl/axis_offset_gen.sv
// Stick value to slew-limited per-motor offsets with link-loss failsafe; optional trim via AXIS_OFFSET_GEN_TRIM_EN.
// Latency: target one clock after rec_valid; offsets move at most SLEW per tick, registered one clock after current.
// Backpressure: none; rec_valid is a strobe that is always accepted.
module axis_offset_gen #(
  parameter int IN_W          = 8,
  parameter int OUT_W         = 8,
  parameter int CENTER        = 20,
  parameter int DEADBAND      = 2,
  parameter int STEP          = 3,
  parameter int MAX_OFFSET    = 6,
  parameter int SLEW          = 1,
  parameter int TICK_DIV      = 4,
  parameter int TIMEOUT_TICKS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  rec_val,
  input  logic             rec_valid,
`ifdef AXIS_OFFSET_GEN_TRIM_EN
  input  logic signed [4:0] trim_val,
  input  logic             trim_load,
`endif
  output logic [OUT_W-1:0] motor_1_offset,
  output logic [OUT_W-1:0] motor_2_offset,
  output logic [OUT_W-1:0] motor_3_offset,
  output logic [OUT_W-1:0] motor_4_offset,
  output logic             settled,
  output logic             link_lost
);

  localparam int CW  = IN_W + 2;
  localparam int MW  = IN_W + 1;
  localparam int SW  = OUT_W + 2;
  localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TOW = $clog2(TIMEOUT_TICKS + 1);

  typedef enum logic [1:0] {IDLE, TRACK, FAILSAFE} state_t;

  state_t                  state_q, state_d;
  logic [TW-1:0]           tick_cnt;
  logic                    tick;
  logic [TOW-1:0]          to_q, to_d;
  logic signed [OUT_W:0]   target_q, target_d, cur_q, cur_d, new_target;
  logic [IN_W-1:0]         center;
  logic [MW-1:0]           mag, quo;
  logic [OUT_W-1:0]        level;
  logic signed [SW-1:0]    delta, delta_abs, step, stepped;

`ifdef AXIS_OFFSET_GEN_TRIM_EN
  logic signed [4:0]       trim_q;
  logic signed [CW-1:0]    c_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            trim_q <= '0;
    else if (trim_load) trim_q <= trim_val;
  end

  always_comb begin
    c_sum = $signed(CW'(CENTER)) + $signed({{(CW-5){trim_q[4]}}, trim_q});
    if (c_sum < 0)                              center = '0;
    else if (c_sum > CW'((1 << IN_W) - 1))      center = '1;
    else                                        center = c_sum[IN_W-1:0];
  end
`else
  assign center = IN_W'(CENTER);
`endif

  // Magnitude is taken in the ordered direction so it can never wrap.
  always_comb begin
    mag = (rec_val > center) ? (MW'(rec_val) - MW'(center)) : (MW'(center) - MW'(rec_val));
    quo = (mag - MW'(DEADBAND + 1)) / MW'(STEP) + MW'(1);
    if (mag <= MW'(DEADBAND))          level = '0;
    else if (quo >= MW'(MAX_OFFSET))   level = OUT_W'(MAX_OFFSET);
    else                               level = OUT_W'(quo);
    new_target = '0;
    if (rec_val > center)      new_target = $signed({1'b0, level});
    else if (rec_val < center) new_target = -$signed({1'b0, level});
  end

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  // Slew step is clamped at zero so a sign reversal always lands on 0 first.
  always_comb begin
    delta     = $signed({target_q[OUT_W], target_q}) - $signed({cur_q[OUT_W], cur_q});
    delta_abs = (delta < 0) ? -delta : delta;
    step      = (delta_abs < SW'(SLEW)) ? delta_abs : SW'(SLEW);
    stepped   = $signed({cur_q[OUT_W], cur_q});
    if (delta > 0) begin
      stepped = stepped + step;
      if (cur_q < 0 && stepped > 0) stepped = '0;
    end else if (delta < 0) begin
      stepped = stepped - step;
      if (cur_q > 0 && stepped < 0) stepped = '0;
    end
    cur_d = tick ? stepped[OUT_W:0] : cur_q;
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    to_d     = to_q;
    case (state_q)
      IDLE: begin
        if (rec_valid) begin
          state_d  = TRACK;
          target_d = new_target;
          to_d     = '0;
        end
      end
      TRACK: begin
        if (rec_valid) begin
          target_d = new_target;
          to_d     = '0;
        end else if (tick) begin
          if (to_q == TOW'(TIMEOUT_TICKS - 1)) begin
            state_d  = FAILSAFE;
            target_d = '0;
            to_d     = '0;
          end else begin
            to_d = to_q + 1'b1;
          end
        end
      end
      FAILSAFE: begin
        if (rec_valid) begin
          state_d  = TRACK;
          target_d = new_target;
          to_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      tick_cnt       <= '0;
      to_q           <= '0;
      target_q       <= '0;
      cur_q          <= '0;
      motor_1_offset <= '0;
      motor_3_offset <= '0;
      settled        <= 1'b1;
    end else begin
      state_q        <= state_d;
      tick_cnt       <= tick ? '0 : tick_cnt + 1'b1;
      to_q           <= to_d;
      target_q       <= target_d;
      cur_q          <= cur_d;
      motor_1_offset <= (cur_q > 0) ? OUT_W'(cur_q) : '0;
      motor_3_offset <= (cur_q < 0) ? OUT_W'(-cur_q) : '0;
      settled        <= (cur_q == target_q);
    end
  end

  assign motor_2_offset = motor_1_offset;
  assign motor_4_offset = motor_3_offset;
  assign link_lost      = (state_q == FAILSAFE);

endmodule

// File: tb/tb_axis_offset_gen.sv
// Bench for axis_offset_gen: per-cycle scoreboard from a behavioural model, target-law table, and ramp/failsafe/reset sequences.
module tb_axis_offset_gen;

  localparam int IN_W = 8, OUT_W = 8, CENTER = 20, DEADBAND = 2, STEP = 3;
  localparam int MAX_OFFSET = 6, SLEW = 1, TICK_DIV = 4, TIMEOUT_TICKS = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [IN_W-1:0]  rec_val = '0;
  logic             rec_valid = 1'b0;
  logic [OUT_W-1:0] motor_1_offset, motor_2_offset, motor_3_offset, motor_4_offset;
  logic             settled, link_lost;
`ifdef AXIS_OFFSET_GEN_TRIM_EN
  logic signed [4:0] trim_val = '0;
  logic              trim_load = 1'b0;
`endif

  axis_offset_gen #(
    .IN_W(IN_W), .OUT_W(OUT_W), .CENTER(CENTER), .DEADBAND(DEADBAND), .STEP(STEP),
    .MAX_OFFSET(MAX_OFFSET), .SLEW(SLEW), .TICK_DIV(TICK_DIV), .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .rec_val(rec_val), .rec_valid(rec_valid),
`ifdef AXIS_OFFSET_GEN_TRIM_EN
    .trim_val(trim_val), .trim_load(trim_load),
`endif
    .motor_1_offset(motor_1_offset), .motor_2_offset(motor_2_offset),
    .motor_3_offset(motor_3_offset), .motor_4_offset(motor_4_offset),
    .settled(settled), .link_lost(link_lost)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  typedef struct { int m12; int m34; bit st; bit ll; } exp_t;
  exp_t sb_q[$];
  int m_tc, m_to, m_tgt, m_cur, m_state;   // m_state: 0 idle, 1 track, 2 failsafe

  function automatic int law(input int v);
    int m, lvl;
    m = (v > CENTER) ? v - CENTER : CENTER - v;
    if (m <= DEADBAND) lvl = 0;
    else lvl = (m - DEADBAND - 1) / STEP + 1;
    if (lvl > MAX_OFFSET) lvl = MAX_OFFSET;
    return (v > CENTER) ? lvl : -lvl;
  endfunction

  function automatic int slew_to(input int cur, input int tgt);
    int d, nxt;
    d = tgt - cur;
    if (d > SLEW)  d = SLEW;
    if (d < -SLEW) d = -SLEW;
    nxt = cur + d;
    if ((cur > 0 && nxt < 0) || (cur < 0 && nxt > 0)) nxt = 0;
    return nxt;
  endfunction

  always @(posedge clk or posedge rst) begin : mdl
    bit tk;
    exp_t e;
    if (rst) begin
      m_tc = 0; m_to = 0; m_tgt = 0; m_cur = 0; m_state = 0;
      sb_q.delete();
    end else begin
      tk    = (m_tc == TICK_DIV - 1);
      e.m12 = (m_cur > 0) ? m_cur : 0;
      e.m34 = (m_cur < 0) ? -m_cur : 0;
      e.st  = (m_cur == m_tgt);
      if (tk) m_cur = slew_to(m_cur, m_tgt);
      if (rec_valid) begin
        m_state = 1; m_tgt = law(int'(rec_val)); m_to = 0;
      end else if (m_state == 1 && tk) begin
        m_to++;
        if (m_to >= TIMEOUT_TICKS) begin m_state = 2; m_tgt = 0; end
      end
      m_tc  = tk ? 0 : m_tc + 1;
      e.ll  = (m_state == 2);
      sb_q.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("sb_cycle",
          {30'd0, motor_1_offset, motor_2_offset, motor_3_offset, motor_4_offset, settled, link_lost},
          {30'd0, OUT_W'(e.m12), OUT_W'(e.m12), OUT_W'(e.m34), OUT_W'(e.m34), e.st, e.ll});
    end
  end

  // ---------------- stimulus helpers ----------------
  int ch12, ch34, overlap, step_err, min_gap;
  bit link_seen;

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic strobe(input int v);
    rec_val = IN_W'(v);
    rec_valid = 1'b1;
    @(posedge clk); #1;
    rec_valid = 1'b0;
  endtask

  // Runs n clocks, optionally re-strobing the held rec_val every 12 clocks, and records output activity.
  task automatic observe(input int n, input bit keep);
    int p12, p34, last_chg;
    ch12 = 0; ch34 = 0; overlap = 0; step_err = 0; min_gap = 1000; link_seen = 0; last_chg = -1;
    p12 = int'(motor_1_offset); p34 = int'(motor_3_offset);
    for (int i = 0; i < n; i++) begin
      rec_valid = keep && (i % 12 == 11);
      @(posedge clk); #1;
      rec_valid = 1'b0;
      if (int'(motor_1_offset) != p12 || int'(motor_3_offset) != p34) begin
        if (int'(motor_1_offset) != p12) ch12++;
        if (int'(motor_3_offset) != p34) ch34++;
        if (iabs(int'(motor_1_offset) - p12) + iabs(int'(motor_3_offset) - p34) != SLEW) step_err++;
        if (last_chg >= 0 && i - last_chg < min_gap) min_gap = i - last_chg;
        last_chg = i;
      end
      if (motor_1_offset != 0 && motor_3_offset != 0) overlap++;
      if (link_lost) link_seen = 1;
      p12 = int'(motor_1_offset); p34 = int'(motor_3_offset);
    end
  endtask

  typedef struct { int val; int e12; int e34; } vec_t;
  vec_t tbl[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{20, 0, 0};  tbl[1]  = '{22, 0, 0};  tbl[2]  = '{23, 1, 0};
    tbl[3]  = '{26, 2, 0};  tbl[4]  = '{25, 1, 0};  tbl[5]  = '{18, 0, 0};
    tbl[6]  = '{17, 0, 1};  tbl[7]  = '{14, 0, 2};  tbl[8]  = '{0, 0, 6};
    tbl[9]  = '{255, 6, 0}; tbl[10] = '{38, 6, 0};  tbl[11] = '{37, 5, 0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_front", motor_1_offset, 0);
    chk("reset_rear", motor_3_offset, 0);
    chk("reset_settled", settled, 1);
    chk("reset_link", link_lost, 0);

    // Neutral stick
    strobe(20);
    observe(8, 1);
    chk("t1_outputs", {motor_1_offset, motor_3_offset}, 0);
    chk("t1_settled", settled, 1);
    chk("t1_link", link_lost, 0);

    // Full rear deflection ramps one level per tick
    strobe(0);
    observe(40, 1);
    chk("t2_rear_steps", ch34, 6);
    chk("t2_front_steps", ch12, 0);
    chk("t2_gap", min_gap, TICK_DIV);
    chk("t2_step_size", step_err, 0);
    chk("t2_final", motor_3_offset, 6);
    chk("t2_settled", settled, 1);

    // Reversal passes through zero, never both pairs active
    strobe(40);
    observe(60, 1);
    chk("t3_rear_steps", ch34, 6);
    chk("t3_front_steps", ch12, 6);
    chk("t3_overlap", overlap, 0);
    chk("t3_gap", min_gap, TICK_DIV);
    chk("t3_step_size", step_err, 0);
    chk("t3_final", {motor_1_offset, motor_3_offset}, {8'd6, 8'd0});

    // Target law boundaries
    for (int k = 0; k < 12; k++) begin
      strobe(tbl[k].val);
      observe(60, 1);
      chk($sformatf("t4_val%0d_front", tbl[k].val), motor_1_offset, tbl[k].e12);
      chk($sformatf("t4_val%0d_rear", tbl[k].val), motor_3_offset, tbl[k].e34);
      chk($sformatf("t4_val%0d_settled", tbl[k].val), settled, 1);
    end

    // Link loss: hold at 4, stop strobing
    strobe(32);
    observe(40, 1);
    chk("t5_steady", motor_1_offset, 4);
    strobe(32);
    observe(27, 0);
    chk("t5_no_early_failsafe", link_lost, 0);
    observe(5, 0);
    chk("t5_failsafe", link_lost, 1);
    chk("t5_no_jump", motor_1_offset, 4);
    observe(24, 0);
    chk("t5_ramp_steps", ch12, 4);
    chk("t5_ramp_size", step_err, 0);
    chk("t5_ramp_final", motor_1_offset, 0);
    chk("t5_still_lost", link_lost, 1);
    strobe(30);
    chk("t5_recover", link_lost, 0);
    observe(30, 1);
    chk("t5_recover_steps", ch12, 3);
    chk("t5_recover_final", motor_1_offset, 3);

    // rec_valid on the exact expiry tick keeps TRACK
    strobe(30);
    begin : align
      bit found;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
        if (m_state == 1 && m_to == TIMEOUT_TICKS - 1 && m_tc == TICK_DIV - 1) found = 1;
        else begin @(posedge clk); #1; end
      end
      chk("corner_aligned", found, 1);
      strobe(30);
      chk("corner_valid_wins", link_lost, 0);
      observe(4, 0);
      chk("corner_no_failsafe", link_seen, 0);
    end

    // Asynchronous reset in the middle of a ramp
    strobe(40);
    chk("t6_pre_reset", motor_1_offset, 3);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_outputs", {motor_1_offset, motor_2_offset, motor_3_offset, motor_4_offset}, 0);
    chk("t6_async_settled", settled, 1);
    chk("t6_async_link", link_lost, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    observe(60, 0);
    chk("t6_idle_front", ch12, 0);
    chk("t6_idle_rear", ch34, 0);
    chk("t6_idle_link", link_seen, 0);
    chk("t6_idle_settled", settled, 1);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
